// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and sizing helper for the BCD-to-binary converter.
package bcd_pkg;

    localparam int BCD_DIGIT_W    = 4;
    localparam int BCD_ADJ_THRESH = 8;
    localparam int BCD_ADJ        = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// One-digit correction for reverse double-dabble: a shifted nibble of 8 or more loses 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nibble_in,
    output logic [BCD_DIGIT_W-1:0] nibble_out
);

    localparam logic [BCD_DIGIT_W-1:0] THRESH = BCD_DIGIT_W'(BCD_ADJ_THRESH);
    localparam logic [BCD_DIGIT_W-1:0] ADJ    = BCD_DIGIT_W'(BCD_ADJ);

    // A nibble >= 8 minus 3 is still >= 5, so no borrow ever leaves the digit.
    always_comb begin
        nibble_out = nibble_in;
        if (nibble_in >= THRESH) begin
            nibble_out = nibble_in - ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential reverse double-dabble: packed BCD in, unsigned binary out, one shift per clock.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = 5,
    parameter int BIN_W  = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic [BIN_W-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(BIN_W);

    // Handshake: start is sampled only in IDLE; the accepting edge raises busy,
    // busy stays high until done, done is a single-cycle pulse with bin/err valid,
    // and start seen while busy or during done is dropped, never queued.

    state_t state;
    state_t state_next;

    logic [BCD_W-1:0] bcd_part;
    logic [BIN_W-1:0] bin_part;
    logic [CNT_W-1:0] count;
    logic             bad;

    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_adj;
    logic [BIN_W-1:0] bin_shift;
    logic             input_bad;
    logic             last_shift;

    assign bcd_shift  = bcd_part >> 1;
    assign bin_shift  = {bcd_part[0], bin_part[BIN_W-1:1]};
    assign last_shift = (count == LAST_COUNT);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_digit_adjust u_adj (
                .nibble_in  (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .nibble_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_comb begin
        input_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(9)) begin
                input_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last_shift) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    // A non-decimal input parks the counter at its final value, so SHIFT lasts one
    // cycle and the DONE pulse reports the error with a zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_part <= '0;
            bin_part <= '0;
            count    <= '0;
            bad      <= 1'b0;
            bin      <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err      <= 1'b0;
                        bad      <= input_bad;
                        bin_part <= '0;
                        bcd_part <= input_bad ? '0 : bcd;
                        count    <= input_bad ? LAST_COUNT : '0;
                    end
                end
                SHIFT: begin
                    if (!last_shift) begin
                        bcd_part <= bcd_adj;
                        bin_part <= bin_shift;
                        count    <= count + CNT_W'(1);
                    end else begin
                        bin <= bad ? '0 : bin_part;
                        err <= bad;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    a_bcd_drained: assert property (@(posedge clk) disable iff (!rst_n)
        (state == SHIFT && last_shift && !bad) |-> (bcd_part == '0));

endmodule
